gps_integrate_dump: RTL and testbench
=====================================

Name: gps_integrate_dump

Overview:
- Integrate-and-dump stage directly downstream of the DDS carrier wipe-off / complex-multiply stage.
- Consumes signed I/Q products as an AXI-stream and accumulates I and Q independently over a programmable number of samples (dump length).
- At the end of each block, emits the pair of sums as one AXI-stream beat to the tracking/acquisition logic.

Parameters:
- IN_W, 16, width of each signed input component (I and Q).
- ACC_W, 32, width of each signed accumulator/output component; must be >= IN_W.
- CNT_W, 16, width of the dump-length configuration and sample counter.

Ports:
- aclk  in  1  clock; all logic rising-edge.
- areset  in  1  asynchronous active-high reset.
- s_axis_tdata  in  2*IN_W  input sample; [IN_W-1:0]=I, [2*IN_W-1:IN_W]=Q, two's complement.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tready  out  1  block accepts input.
- cfg_dump_len  in  CNT_W  samples per dump; 0 is illegal and ignored.
- cfg_valid  in  1  single-cycle strobe that loads cfg_dump_len.
- m_axis_tdata  out  2*ACC_W  dump result; [ACC_W-1:0]=I sum, upper half=Q sum.
- m_axis_tvalid  out  1  dump result valid.
- m_axis_tready  in  1  downstream accepts result.
- overflow  out  1  sticky accumulator-saturation flag.
- dump_count  out  CNT_W  number of dumps emitted; wraps.

Behaviour:
- Reset (async assert, sync-released use): state IDLE; accumulators, counter, dump_count, m_axis_tdata = 0; m_axis_tvalid=0; s_axis_tready=0; overflow=0; active and shadow length = 0.
- States:
  - IDLE: no valid length loaded; s_axis_tready=0.
  - ACCUM: integrating.
- IDLE->ACCUM: on the cycle after cfg_valid with nonzero cfg_dump_len. The length goes to both the shadow and active registers, and the counter is cleared.
- cfg_valid in ACCUM: nonzero length written to the shadow register only. The active length is replaced from the shadow at the next block boundary; the current block completes with the old length.
- Acceptance: a sample is accepted when s_axis_tvalid && s_axis_tready.
  - Each accepted sample adds its sign-extended I and Q to the respective accumulators.
  - The counter increments on each accepted sample.
- Last sample: an accepted sample with counter == active_len-1.
  - m_axis_tdata loads accumulator+sample on the following edge, and m_axis_tvalid=1 (1-cycle latency).
  - Accumulators and counter clear to 0; dump_count increments.
- Output handshake:
  - m_axis_tvalid holds, and m_axis_tdata is stable, until m_axis_tready.
  - A new dump and a downstream accept in the same cycle: new data loads and valid stays 1.
- Backpressure: s_axis_tready = (state==ACCUM) && !(counter==active_len-1 && m_axis_tvalid && !m_axis_tready). Non-last samples are never stalled by the output.
- active_len=1: every accepted sample produces a dump. The input runs at full rate while m_axis_tready=1.
- Arithmetic: wrapping two's-complement at ACC_W unless the optional feature is enabled.
- Mid-operation reset: all state is discarded immediately (async) and the partial block is lost.

Optional Feature:
- Macro: GPS_INTEGRATE_DUMP_SAT_EN.
- Defined:
  - Each accumulator saturates at +(2^(ACC_W-1)-1) / -(2^(ACC_W-1)) instead of wrapping.
  - Any saturation event sets overflow, which is sticky until areset.
  - The dump output carries the saturated value.
- Undefined: accumulators wrap modulo 2^ACC_W; overflow is tied 0.

Test Plan:
- Length 4; I=1,2,3,4 and Q=-1 each; m_axis_tready=1 -> one beat, I=10 and Q=-4, m_axis_tvalid exactly 1 cycle after the 4th accept; dump_count=1.
- Length 1; 8 back-to-back samples I=k, Q=-k for k=0..7, tvalid held -> 8 beats matching the inputs; s_axis_tready stays 1 throughout; dump_count=8.
- Length 2 with m_axis_tready=0 after the first dump -> s_axis_tready drops on the 2nd sample of block 2; the first result is held stable. Releasing tready -> the result drains, then the block-2 sum (I=3 for inputs 1,2) appears on the next cycle.
- Length 4; cfg_valid with length 2 after 2 samples -> the current block dumps after 4 samples; the following blocks dump every 2.
- Assert areset after 3 of 4 samples -> all outputs return to 0 and state IDLE; s_axis_tready=0 until a new cfg_valid.
- ACC_W=IN_W=16, length 2, I=0x7FFF twice -> with GPS_INTEGRATE_DUMP_SAT_EN: I=0x7FFF and overflow=1; without: I=0xFFFE (wrap) and overflow=0.

Source files
------------

// File: rtl/gps_integrate_dump.sv
// gps_integrate_dump: I/Q integrate-and-dump over a programmable block length; define GPS_INTEGRATE_DUMP_SAT_EN for saturating accumulators
module gps_integrate_dump #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [2*IN_W-1:0]  s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [CNT_W-1:0]   cfg_dump_len,
  input  logic               cfg_valid,
  output logic [2*ACC_W-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               overflow,
  output logic [CNT_W-1:0]   dump_count
);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_nxt;
  logic [ACC_W-1:0] acc_i, acc_q, sum_i, sum_q;
  logic [CNT_W-1:0] cnt, active_len, shadow_len;
  logic signed [IN_W-1:0] in_i, in_q;
  logic cfg_ok, at_last, accept, last;
  assign in_i = s_axis_tdata[IN_W-1:0];
  assign in_q = s_axis_tdata[2*IN_W-1:IN_W];
  assign cfg_ok = cfg_valid && cfg_dump_len != '0;
  assign at_last = cnt == active_len - CNT_W'(1);
  // only the block-closing sample waits for the output register to free up
  assign s_axis_tready = state == ACCUM && !(at_last && m_axis_tvalid && !m_axis_tready);
  assign accept = s_axis_tvalid && s_axis_tready;
  assign last = accept && at_last;
`ifdef GPS_INTEGRATE_DUMP_SAT_EN
  logic [ACC_W:0] wide_i, wide_q;
  logic sat_i, sat_q;
  assign wide_i = {acc_i[ACC_W-1], acc_i} + (ACC_W+1)'(in_i);
  assign wide_q = {acc_q[ACC_W-1], acc_q} + (ACC_W+1)'(in_q);
  assign sat_i = wide_i[ACC_W] ^ wide_i[ACC_W-1];
  assign sat_q = wide_q[ACC_W] ^ wide_q[ACC_W-1];
  assign sum_i = sat_i ? {wide_i[ACC_W], {(ACC_W-1){~wide_i[ACC_W]}}} : wide_i[ACC_W-1:0];
  assign sum_q = sat_q ? {wide_q[ACC_W], {(ACC_W-1){~wide_q[ACC_W]}}} : wide_q[ACC_W-1:0];
  // sticky flag set by any clipped accumulation
  always_ff @(posedge aclk or posedge areset)
    if (areset) overflow <= 1'b0;
    else if (accept && (sat_i || sat_q)) overflow <= 1'b1;
`else
  assign sum_i = acc_i + ACC_W'(in_i);
  assign sum_q = acc_q + ACC_W'(in_q);
  assign overflow = 1'b0;
`endif
  // state register
  always_ff @(posedge aclk or posedge areset)
    if (areset) state <= IDLE;
    else state <= state_nxt;
  // leave IDLE once a usable length arrives; ACCUM is held until reset
  always_comb begin
    state_nxt = state;
    if (state == IDLE && cfg_ok) state_nxt = ACCUM;
  end
  // accumulation, block boundary handling and output register
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      acc_i         <= '0;
      acc_q         <= '0;
      cnt           <= '0;
      active_len    <= '0;
      shadow_len    <= '0;
      dump_count    <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (cfg_ok) begin
          active_len <= cfg_dump_len;
          shadow_len <= cfg_dump_len;
          cnt        <= '0;
        end
      end else begin
        if (cfg_ok) shadow_len <= cfg_dump_len;
        if (last) begin
          active_len   <= cfg_ok ? cfg_dump_len : shadow_len;
          acc_i        <= '0;
          acc_q        <= '0;
          cnt          <= '0;
          dump_count   <= dump_count + CNT_W'(1);
          m_axis_tdata <= {sum_q, sum_i};
        end else if (accept) begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          cnt   <= cnt + CNT_W'(1);
        end
      end
      m_axis_tvalid <= last || (m_axis_tvalid && !m_axis_tready);
    end
endmodule

// File: tb/tb_gps_integrate_dump.sv
// tb_gps_integrate_dump: scoreboard bench for gps_integrate_dump, plus a 16-bit instance for the overflow case
module tb_gps_integrate_dump;
  logic aclk = 0, areset = 1;
  logic [31:0] s_tdata = '0;
  logic s_tvalid = 0, s_tready;
  logic [15:0] cfg_len = '0;
  logic cfg_valid = 0;
  logic [63:0] m_tdata;
  logic m_tvalid, m_tready = 1, ovf;
  logic [15:0] dcount;
  logic [31:0] s2_tdata = '0;
  logic s2_tvalid = 0, s2_tready;
  logic [15:0] s2_cfg_len = '0;
  logic s2_cfg_valid = 0;
  logic [31:0] s2_m_tdata;
  logic s2_m_tvalid, s2_ovf;
  logic [15:0] s2_dcount;
  int checks = 0, failures = 0, stalls = 0;
  logic [63:0] exp_q[$];

  always #5 aclk = ~aclk;

  gps_integrate_dump dut (
    .aclk(aclk), .areset(areset), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .cfg_dump_len(cfg_len), .cfg_valid(cfg_valid),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .overflow(ovf), .dump_count(dcount)
  );

  gps_integrate_dump #(.IN_W(16), .ACC_W(16), .CNT_W(16)) dut_s (
    .aclk(aclk), .areset(areset), .s_axis_tdata(s2_tdata), .s_axis_tvalid(s2_tvalid),
    .s_axis_tready(s2_tready), .cfg_dump_len(s2_cfg_len), .cfg_valid(s2_cfg_valid),
    .m_axis_tdata(s2_m_tdata), .m_axis_tvalid(s2_m_tvalid), .m_axis_tready(1'b1),
    .overflow(s2_ovf), .dump_count(s2_dcount)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int i, input int q);
    return {32'(q), 32'(i)};
  endfunction

  // scoreboard: every output transfer is matched against the oldest expected beat
  always @(negedge aclk)
    if (!areset && m_tvalid && m_tready) begin
      check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("beat", m_tdata, exp_q.pop_front());
    end

  task automatic do_reset();
    s_tvalid = 0; cfg_valid = 0; m_tready = 1;
    areset = 1;
    repeat (2) @(posedge aclk);
    #1 areset = 0;
  endtask

  task automatic cfg(input int n);
    @(posedge aclk); #1;
    cfg_len = 16'(n); cfg_valid = 1;
    @(posedge aclk); #1;
    cfg_valid = 0;
  endtask

  task automatic send(input int i, input int q);
    int n = 0;
    s_tdata = {16'(q), 16'(i)};
    s_tvalid = 1;
    do begin
      @(negedge aclk);
      n++;
    end while (!s_tready && n < 50);
    if (!s_tready) check("send_timeout", 64'(s_tready), 64'd1);
    stalls += n - 1;
    @(posedge aclk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge aclk); #1;
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    do_reset();
    check("rst_s_tready", 64'(s_tready), 0);
    check("rst_m_tvalid", 64'(m_tvalid), 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_dcount", 64'(dcount), 0);
    check("rst_ovf", 64'(ovf), 0);

    // length 4 single block, one-cycle dump latency
    cfg(4);
    exp_q.push_back(pk(10, -4));
    send(1, -1); send(2, -1); send(3, -1);
    check("t1_no_early", 64'(m_tvalid), 0);
    send(4, -1);
    s_tvalid = 0;
    check("t1_valid", 64'(m_tvalid), 1);
    @(posedge aclk); #1;
    check("t1_valid_1cyc", 64'(m_tvalid), 0);
    drain();
    check("t1_dcount", 64'(dcount), 1);

    // length 1 at full rate
    do_reset();
    cfg(1);
    stalls = 0;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(pk(k, -k));
      send(k, -k);
    end
    s_tvalid = 0;
    check("t2_stalls", 64'(stalls), 0);
    drain();
    check("t2_dcount", 64'(dcount), 8);

    // length 2 with output backpressure
    do_reset();
    cfg(2);
    exp_q.push_back(pk(10, 10));
    exp_q.push_back(pk(3, 0));
    send(5, 5); send(5, 5);
    m_tready = 0;
    send(1, 0);
    s_tdata = {16'd0, 16'd2};
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      check("t3_stall", 64'(s_tready), 0);
      check("t3_hold", m_tdata, pk(10, 10));
      check("t3_hold_valid", 64'(m_tvalid), 1);
    end
    @(posedge aclk); #1;
    m_tready = 1;
    send(2, 0);
    s_tvalid = 0;
    check("t3_block2", m_tdata, pk(3, 0));
    check("t3_block2_valid", 64'(m_tvalid), 1);
    drain();

    // length change mid-block takes effect at the next boundary
    do_reset();
    cfg(4);
    send(1, 1); send(1, 1);
    s_tvalid = 0;
    cfg(2);
    exp_q.push_back(pk(4, 4));
    send(1, 1); send(1, 1);
    exp_q.push_back(pk(3, 0));
    exp_q.push_back(pk(7, 0));
    for (int k = 1; k <= 4; k++) send(k, 0);
    s_tvalid = 0;
    drain();
    check("t4_dcount", 64'(dcount), 3);

    // reset in the middle of a block
    do_reset();
    cfg(4);
    exp_q.push_back(pk(8, 12));
    for (int k = 0; k < 4; k++) send(2, 3);
    send(1, 1); send(1, 1); send(1, 1);
    s_tvalid = 0;
    drain();
    check("t5_pre_data", m_tdata, pk(8, 12));
    areset = 1;
    #1;
    check("t5_s_tready", 64'(s_tready), 0);
    check("t5_m_tvalid", 64'(m_tvalid), 0);
    check("t5_m_tdata", m_tdata, 0);
    check("t5_dcount", 64'(dcount), 0);
    @(posedge aclk); #1;
    areset = 0;
    s_tdata = {16'd1, 16'd1};
    s_tvalid = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      check("t5_idle_ready", 64'(s_tready), 0);
    end
    @(posedge aclk); #1;
    s_tvalid = 0;
    cfg(4);
    exp_q.push_back(pk(4, 4));
    for (int k = 0; k < 4; k++) send(1, 1);
    s_tvalid = 0;
    drain();
    check("t5_ovf_main", 64'(ovf), 0);

    // 16-bit accumulators pushed past full scale
    @(posedge aclk); #1;
    s2_cfg_len = 16'd2; s2_cfg_valid = 1;
    @(posedge aclk); #1;
    s2_cfg_valid = 0;
    s2_tdata = {16'h0000, 16'h7FFF};
    s2_tvalid = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge aclk);
      check("t6_ready", 64'(s2_tready), 1);
      @(posedge aclk); #1;
    end
    s2_tvalid = 0;
    check("t6_valid", 64'(s2_m_tvalid), 1);
`ifdef GPS_INTEGRATE_DUMP_SAT_EN
    check("t6_sum", 64'(s2_m_tdata), 64'h7FFF);
    check("t6_ovf", 64'(s2_ovf), 1);
`else
    check("t6_sum", 64'(s2_m_tdata), 64'hFFFE);
    check("t6_ovf", 64'(s2_ovf), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
